// File: rtl/arf066b064e1r1w0cbbehsaa4acw_wr_sched_if.sv
// rtl/arf066b064e1r1w0cbbehsaa4acw_wr_sched_if.sv - write-requester bus into the write-port scheduler
interface arf066b064e1r1w0cbbehsaa4acw_wr_sched_if #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 64
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/arf066b064e1r1w0cbbehsaa4acw_wr_sched.sv
// rtl/arf066b064e1r1w0cbbehsaa4acw_wr_sched.sv - round-robin write-port scheduler with stage and read bypass
module arf066b064e1r1w0cbbehsaa4acw_wr_sched #(
  parameter int NREQ   = 4,
  parameter int DEPTH  = 66,
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 7,
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arf066b064e1r1w0cbbehsaa4acw_wr_sched_if.slave req,
  input  logic                 hold,
  output logic                 wr_en,
  output logic [AWIDTH-1:0]    wr_addr,
  output logic [DWIDTH-1:0]    wr_data,
  input  logic [AWIDTH-1:0]    rd_addr,
  input  logic [DWIDTH-1:0]    arr_rd_data,
  output logic [DWIDTH-1:0]    rd_data,
  output logic                 err,
  output logic [PW-1:0]        err_id,
  input  logic                 err_clr
);

  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);

  logic                stage_vld_q, stage_vld_d;
  logic [AWIDTH-1:0]   stage_addr_q, stage_addr_d;
  logic [DWIDTH-1:0]   stage_data_q, stage_data_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;
  logic [PW-1:0]       err_id_q, err_id_d;

  logic [NREQ-1:0]     grant;
  logic                found;
  int                  g_idx;
  int                  idx;
  logic [AWIDTH-1:0]   g_addr;
  logic [DWIDTH-1:0]   g_data;
  logic                can_take;
  logic                accept;
  logic                addr_bad;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    g_idx    = 0;
    idx      = 0;
    // Search starts at rr_ptr so the most recent winner goes to the back of the line.
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req.req_valid[idx]) begin
        found = 1'b1;
        g_idx = idx;
      end
    end
    if (found) grant[g_idx] = 1'b1;

    g_addr   = req.req_addr[g_idx*AWIDTH +: AWIDTH];
    g_data   = req.req_data[g_idx*DWIDTH +: DWIDTH];
    can_take = ~stage_vld_q | ~hold;
    accept   = found & can_take;
    addr_bad = {1'b0, g_addr} >= DEPTH_L;

    stage_vld_d  = stage_vld_q;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    rr_ptr_d     = rr_ptr_q;
    err_d        = err_q;
    err_id_d     = err_id_q;

    if (accept) begin
      // Out-of-range writes are swallowed so the requester never stalls on them.
      stage_vld_d = ~addr_bad;
      if (!addr_bad) begin
        stage_addr_d = g_addr;
        stage_data_d = g_data;
      end
      rr_ptr_d = PW'((g_idx + 1) % NREQ);
    end else if (wr_en) begin
      stage_vld_d = 1'b0;
    end

    if (err_clr) begin
      err_d    = 1'b0;
      err_id_d = '0;
    end else if (accept && addr_bad) begin
      err_d = 1'b1;
      if (!err_q) err_id_d = PW'(g_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld_q  <= 1'b0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
      rr_ptr_q     <= '0;
      err_q        <= 1'b0;
      err_id_q     <= '0;
    end else begin
      stage_vld_q  <= stage_vld_d;
      stage_addr_q <= stage_addr_d;
      stage_data_q <= stage_data_d;
      rr_ptr_q     <= rr_ptr_d;
      err_q        <= err_d;
      err_id_q     <= err_id_d;
    end
  end

  assign req.req_ready = grant & {NREQ{can_take}};
  assign wr_en         = stage_vld_q & ~hold;
  assign wr_addr       = stage_addr_q;
  assign wr_data       = stage_data_q;
  // Array latches are transparent in the low phase, so the same-cycle write must be forwarded.
  assign rd_data       = (wr_en && (rd_addr == stage_addr_q)) ? stage_data_q : arr_rd_data;
  assign err           = err_q;
  assign err_id        = err_id_q;

endmodule

// File: tb/tb_arf066b064e1r1w0cbbehsaa4acw_wr_sched.sv
// tb/tb_arf066b064e1r1w0cbbehsaa4acw_wr_sched.sv - directed-vector bench for the write-port scheduler
module tb_arf066b064e1r1w0cbbehsaa4acw_wr_sched;

  localparam int NREQ   = 4;
  localparam int DEPTH  = 66;
  localparam int DWIDTH = 64;
  localparam int AWIDTH = 7;

  logic              clk;
  logic              rst_n;
  logic              hold;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] arr_rd_data;
  logic [DWIDTH-1:0] rd_data;
  logic              err;
  logic [1:0]        err_id;
  logic              err_clr;

  int vectors;
  int miscompares;

  arf066b064e1r1w0cbbehsaa4acw_wr_sched_if #(.NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) rq ();

  arf066b064e1r1w0cbbehsaa4acw_wr_sched #(
    .NREQ(NREQ), .DEPTH(DEPTH), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(rq),
    .hold(hold),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .arr_rd_data(arr_rd_data),
    .rd_data(rd_data),
    .err(err),
    .err_id(err_id),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    rq.req_addr[i*AWIDTH +: AWIDTH] = a;
    rq.req_data[i*DWIDTH +: DWIDTH] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] D_T1 = 64'hA5A5_0000_0000_1234;
  localparam logic [63:0] D_H1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D_H2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D_BY = 64'hCAFE_F00D_0BAD_BEEF;
  localparam logic [63:0] D_AR = 64'hDEAD_0000_BEEF_0001;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    hold         = 1'b0;
    err_clr      = 1'b0;
    rd_addr      = '0;
    arr_rd_data  = D_AR;
    rq.req_valid = '0;
    rq.req_addr  = '0;
    rq.req_data  = '0;

    #12;
    chk("rst_wr_en",   64'(wr_en),   64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data,      64'd0);
    chk("rst_err",     64'(err),     64'd0);
    chk("rst_err_id",  64'(err_id),  64'd0);
    chk("rst_ready",   64'(rq.req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single write from requester 2
    set_req(2, 7'd5, D_T1);
    rq.req_valid = 4'b0100;
    #1 chk("t1_ready", 64'(rq.req_ready), 64'h4);
    tick();
    rq.req_valid = '0;
    #1;
    chk("t1_wr_en",   64'(wr_en),   64'd1);
    chk("t1_wr_addr", 64'(wr_addr), 64'd5);
    chk("t1_wr_data", wr_data,      D_T1);

    // rr_ptr is 3: requester 3 beats requester 0
    set_req(0, 7'd30, 64'h30);
    set_req(3, 7'd31, 64'h31);
    rq.req_valid = 4'b1001;
    #1 chk("rr3_ready", 64'(rq.req_ready), 64'h8);
    tick();
    rq.req_valid = '0;
    #1 chk("rr3_wr_addr", 64'(wr_addr), 64'd31);
    tick();
    chk("rr3_drained", 64'(wr_en), 64'd0);

    // all four valid for 8 cycles: grants 0,1,2,3,0,1,2,3 back to back
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 7'(20 + i), {32'(i), 32'(c)});
      rq.req_valid = 4'hF;
      #1 chk($sformatf("rr_ready_c%0d", c), 64'(rq.req_ready), 64'(1 << (c % 4)));
      tick();
      chk($sformatf("rr_wr_en_c%0d", c),   64'(wr_en),   64'd1);
      chk($sformatf("rr_wr_addr_c%0d", c), 64'(wr_addr), 64'(20 + c % 4));
      chk($sformatf("rr_wr_data_c%0d", c), wr_data,      {32'(c % 4), 32'(c)});
    end
    rq.req_valid = '0;
    tick();
    chk("rr_idle", 64'(wr_en), 64'd0);

    // hold with a full stage
    set_req(1, 7'd40, D_H1);
    rq.req_valid = 4'b0010;
    tick();
    hold = 1'b1;
    set_req(0, 7'd41, D_H2);
    rq.req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold_wr_en_%0d", c),   64'(wr_en),         64'd0);
      chk($sformatf("hold_ready_%0d", c),   64'(rq.req_ready),  64'd0);
      chk($sformatf("hold_wr_addr_%0d", c), 64'(wr_addr),       64'd40);
      chk($sformatf("hold_wr_data_%0d", c), wr_data,            D_H1);
      tick();
    end
    hold = 1'b0;
    #1;
    chk("rel_wr_en",   64'(wr_en),        64'd1);
    chk("rel_wr_addr", 64'(wr_addr),      64'd40);
    chk("rel_ready",   64'(rq.req_ready), 64'h1);
    tick();
    rq.req_valid = '0;
    #1;
    chk("rel_next_wr_en",   64'(wr_en),   64'd1);
    chk("rel_next_wr_addr", 64'(wr_addr), 64'd41);
    chk("rel_next_wr_data", wr_data,      D_H2);
    tick();

    // out-of-range addresses (rr_ptr is 1)
    set_req(1, 7'd70, 64'h70);
    rq.req_valid = 4'b0010;
    #1 chk("oor1_ready", 64'(rq.req_ready), 64'h2);
    tick();
    rq.req_valid = '0;
    #1;
    chk("oor1_wr_en",  64'(wr_en),  64'd0);
    chk("oor1_err",    64'(err),    64'd1);
    chk("oor1_err_id", 64'(err_id), 64'd1);
    set_req(3, 7'd66, 64'h66);
    rq.req_valid = 4'b1000;
    #1 chk("oor3_ready", 64'(rq.req_ready), 64'h8);
    tick();
    rq.req_valid = '0;
    #1;
    chk("oor3_wr_en",  64'(wr_en),  64'd0);
    chk("oor3_err",    64'(err),    64'd1);
    chk("oor3_err_id", 64'(err_id), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err",    64'(err),    64'd0);
    chk("clr_err_id", 64'(err_id), 64'd0);

    // read bypass (rr_ptr is 0)
    set_req(0, 7'd12, D_BY);
    rq.req_valid = 4'b0001;
    tick();
    rq.req_valid = '0;
    rd_addr = 7'd12;
    #1 chk("byp_hit", rd_data, D_BY);
    rd_addr = 7'd13;
    #1 chk("byp_miss", rd_data, D_AR);
    rd_addr = 7'd12;
    hold = 1'b1;
    #1 chk("byp_held", rd_data, D_AR);
    hold = 1'b0;
    #1 chk("byp_wr_en", 64'(wr_en), 64'd1);

    // async reset with a full stage and a live request
    set_req(1, 7'd9, 64'h9);
    rq.req_valid = 4'b0010;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr_en",   64'(wr_en),        64'd0);
    chk("arst_wr_addr", 64'(wr_addr),      64'd0);
    chk("arst_wr_data", wr_data,           64'd0);
    chk("arst_err",     64'(err),          64'd0);
    chk("arst_ready",   64'(rq.req_ready), 64'h2);
    chk("arst_rd_data", rd_data,           D_AR);
    rq.req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arf066b064e1r1w0cbbehsaa4acw_wr_sched.md
# arf066b064e1r1w0cbbehsaa4acw_wr_sched

Write-port scheduler for the 66-entry x 64-bit 1R1W latch register file. Arbitrates up to NREQ write requesters onto the array's single write port with round-robin fairness, stages the winning write for one cycle, drives the array write enable, address and data, and bypasses same-cycle write data onto the read path. Sits between the requesting pipelines and the latch array; it is the only driver of the array write port.

## Interface
- NREQ, 4, number of write requesters (2..8)
- DEPTH, 66, array entries
- DWIDTH, 64, data width
- AWIDTH, 7, address width, >= clog2(DEPTH)
- clk  in  1  clock; array phase-B latches are transparent while clk is low
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester accept; a request is taken when valid & ready
- req_addr  in  NREQ*AWIDTH  packed addresses, requester i at [i*AWIDTH +: AWIDTH]
- req_data  in  NREQ*DWIDTH  packed data, requester i at [i*DWIDTH +: DWIDTH]
- hold  in  1  stall the write port (test/scan window)
- wr_en  out  1  array write enable, registered
- wr_addr  out  AWIDTH  array write address, registered
- wr_data  out  DWIDTH  array write data, registered
- rd_addr  in  AWIDTH  array read address (pass-through compare only)
- arr_rd_data  in  DWIDTH  raw array read data
- rd_data  out  DWIDTH  read data after bypass
- err  out  1  sticky: out-of-range write address accepted
- err_id  out  clog2(NREQ)  requester of the first out-of-range write
- err_clr  in  1  clears err and err_id

## Operation
- State: stage_vld, stage_addr, stage_data, rr_ptr (clog2(NREQ) bits), err, err_id.
- Arbiter: grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ. The grant is one-hot or zero.
- can_take = ~stage_vld | ~hold.
- req_ready[i] = grant[i] & can_take. Ready is never asserted to a non-requesting port.
- On an accept from requester g: the stage loads the address and data, and rr_ptr becomes (g+1) mod NREQ. With no accept, rr_ptr holds.
- Address check: if req_addr >= DEPTH, the request is still accepted but is not staged (stage_vld=0 next cycle). err is set. err_id is loaded only if err was 0.
- Drain: wr_en = stage_vld & ~hold, and wr_addr/wr_data come from the stage.
  - stage_vld clears after a drain cycle unless a new accept occurs in the same cycle.
  - Under hold, stage_vld stays 1 and the stage holds its contents.
- Bypass: rd_data = stage_data when wr_en and rd_addr == wr_addr. Otherwise rd_data = arr_rd_data.
- err_clr has priority over a same-cycle error set: the register clears and the new error is lost. err_clr is intended for quiescent use.
- Reset values (async, on rst_n low): stage_vld=0, wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, err=0, err_id=0. req_ready then follows the arbiter combinationally (can_take=1). Reset mid-write drops the staged entry with no partial write.

## Timing
- Accept at rising edge T. wr_en/wr_addr/wr_data are valid for cycle T..T+1. The array latches during the clk-low half of that cycle.
- The array read reflects the write from edge T+1. rd_data bypass covers cycle T..T+1.
- Throughput: one write per cycle with hold=0. Latency from accept to wr_en is 1 cycle.
- hold asserted with the stage full: no accept. wr_en=0 from the cycle hold is seen, because wr_en is combinational from the stage and hold. When hold drops, the held entry drains that cycle and a new accept is allowed in the same cycle.
- req_valid may drop without an accept, and may change addr/data while not ready. The scheduler samples only on accept.
- Outputs wr_addr/wr_data are registered. wr_en, req_ready and rd_data have combinational terms from hold, req_valid and rd_addr respectively.

## Test plan
- Reset, then requester 2 writes addr 5 data 0xA5A5_0000_0000_1234. Required: req_ready[2]=1 at the accept edge. Next cycle wr_en=1, wr_addr=5 with the same data. rr_ptr=3.
- All four requesters valid continuously for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3, with one wr_en per cycle and no gaps.
- Stage full and hold=1 for 3 cycles. Required: wr_en=0 and req_ready all 0. The stage is unchanged. On hold release, the held write drains and the next request is accepted in the same cycle.
- Requester 1 writes addr 70. Required: accepted, with no wr_en the next cycle; err=1, err_id=1. A later addr 66 write from requester 3 leaves err_id=1. err_clr then gives err=0.
- wr_en=1 to addr 12 with rd_addr=12. Required: rd_data=wr_data. With rd_addr=13, rd_data=arr_rd_data.
- Assert rst_n=0 while the stage is full and req_valid=1. Required: wr_en drops immediately, and all registered outputs read 0.
